// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Loader, instruction-memory and decode-side bundle of fetch_unit.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int PC_W    = 27,
  parameter int IMEM_AW = 15
);
  logic               ld_valid;
  logic [31:0]        ld_data;
  logic               ld_done;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_we;
  logic [31:0]        imem_wdata;
  logic [31:0]        imem_rdata;
  logic               n_stall;
  logic               dec_nstall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [31:0]        inst;
  logic [PC_W-1:0]    if_pc;
  logic               running;
  logic [IMEM_AW:0]   load_words;

  modport master (
    input  ld_valid, ld_data, ld_done, imem_rdata,
    input  n_stall, dec_nstall, redirect, redirect_pc,
    output imem_addr, imem_we, imem_wdata,
    output inst, if_pc, running, load_words
  );

  modport slave (
    output ld_valid, ld_data, ld_done, imem_rdata,
    output n_stall, dec_nstall, redirect, redirect_pc,
    input  imem_addr, imem_we, imem_wdata,
    input  inst, if_pc, running, load_words
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Boot loader plus PC/instruction-memory fetch stage for decode.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int PC_W    = 27,
  parameter int IMEM_AW = 15
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] c_BOOT  = 2'd0;
  localparam logic [1:0] c_PRIME = 2'd1;
  localparam logic [1:0] c_RUN   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [IMEM_AW:0]   r_wcnt;
  logic [PC_W-1:0]    r_pc_q;
  logic               r_vld;
  logic               r_running;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_redir_pc;
  logic               w_full;
  logic               w_advance;
  logic [IMEM_AW-1:0] w_imem_addr;
  logic               w_imem_we;

  assign w_full     = r_wcnt[IMEM_AW];
  assign w_advance  = bus.n_stall && bus.dec_nstall;
  assign w_pc_inc   = r_pc_q + PC_W'(4);
  assign w_redir_pc = {bus.redirect_pc[PC_W-1:2], 2'b00};

  // The address is chosen combinationally so the synchronous read lands on
  // the next cycle's PC, giving zero-bubble redirects and stable stalls.
  always_comb begin
    w_state_nxt = r_state;
    w_imem_addr = '0;
    w_imem_we   = 1'b0;
    case (r_state)
      c_BOOT: begin
        w_imem_addr = r_wcnt[IMEM_AW-1:0];
        w_imem_we   = rst && bus.ld_valid && !w_full;
        if (bus.ld_done) begin
          w_state_nxt = c_PRIME;
        end
      end
      c_PRIME: begin
        w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (bus.redirect) begin
          w_imem_addr = bus.redirect_pc[IMEM_AW+1:2];
        end else if (w_advance) begin
          w_imem_addr = w_pc_inc[IMEM_AW+1:2];
        end else begin
          w_imem_addr = r_pc_q[IMEM_AW+1:2];
        end
      end
      default: begin
        w_state_nxt = c_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= c_BOOT;
      r_wcnt    <= '0;
      r_pc_q    <= '0;
      r_vld     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == c_RUN);
      case (r_state)
        c_BOOT: begin
          if (w_imem_we) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        c_PRIME: begin
          r_pc_q <= '0;
          r_vld  <= 1'b1;
        end
        c_RUN: begin
          if (bus.redirect) begin
            r_pc_q <= w_redir_pc;
          end else if (w_advance) begin
            r_pc_q <= w_pc_inc;
          end
        end
        default: begin
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr  = w_imem_addr;
  assign bus.imem_we    = w_imem_we;
  assign bus.imem_wdata = bus.ld_data;
  assign bus.inst       = r_vld ? bus.imem_rdata : 32'h0;
  assign bus.if_pc      = r_pc_q;
  assign bus.running    = r_running;
  assign bus.load_words = r_wcnt;

endmodule
`default_nettype wire
